// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The fetch buffer entry carries the word address, the instruction, and a filled flag.
package fetch_unit_pkg;

   localparam logic [31:0] INST_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        filled;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_unit_buffer.sv
// fetch_buffer: a circular buffer of fetch entries.
// Entries are allocated at the tail and filled in order through an oldest-unfilled pointer.
module fetch_buffer
   import fetch_unit_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic          clk_100mhz,
   input  logic          rst_in,
   input  logic          alloc,
   input  logic [31:0]   alloc_pc,
   input  logic          fill,
   input  logic [31:0]   fill_inst,
   input  logic          pop,
   input  logic          flush,
   output fetch_entry_t  head,
   output logic [CW-1:0] count,
   output logic [CW-1:0] unfilled
);

   fetch_entry_t  mem_r [DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [PW-1:0] fill_ptr_r;
   logic [CW-1:0] count_r;
   logic [CW-1:0] unfilled_r;

   // Entry storage, pointers and occupancy counters.
   always_ff @(posedge clk_100mhz or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '{pc: 32'h0000_0000, inst: INST_NOP, filled: 1'b0};
         end
         wr_ptr_r   <= {PW{1'b0}};
         rd_ptr_r   <= {PW{1'b0}};
         fill_ptr_r <= {PW{1'b0}};
         count_r    <= {CW{1'b0}};
         unfilled_r <= {CW{1'b0}};
      end else if (flush) begin
         wr_ptr_r   <= {PW{1'b0}};
         rd_ptr_r   <= {PW{1'b0}};
         fill_ptr_r <= {PW{1'b0}};
         count_r    <= {CW{1'b0}};
         unfilled_r <= {CW{1'b0}};
      end else begin
         if (alloc) begin
            mem_r[wr_ptr_r] <= '{pc: alloc_pc, inst: INST_NOP, filled: 1'b0};
            wr_ptr_r        <= wr_ptr_r + PW'(1);
         end
         if (fill) begin
            mem_r[fill_ptr_r].inst   <= fill_inst;
            mem_r[fill_ptr_r].filled <= 1'b1;
            fill_ptr_r               <= fill_ptr_r + PW'(1);
         end
         if (pop) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         count_r    <= count_r + CW'(alloc) - CW'(pop);
         unfilled_r <= unfilled_r + CW'(alloc) - CW'(fill);
      end
   end

   assign head     = mem_r[rd_ptr_r];
   assign count    = count_r;
   assign unfilled = unfilled_r;

endmodule

// File: rtl/fetch_unit_checker.sv
// Protocol checks for fetch_unit.
// The checker flags a response that has no outstanding request, and any request address that is not word aligned.
module fetch_unit_checker #(
   parameter int CW = 3
) (
   input logic          clk_100mhz,
   input logic          rst_in,
   input logic          resp_valid,
   input logic          req_valid,
   input logic [31:0]   req_addr,
   input logic [CW-1:0] unfilled,
   input logic [CW-1:0] drop_cnt
);

   a_resp_has_request: assert property (@(posedge clk_100mhz) disable iff (!rst_in)
      resp_valid |-> ((unfilled != {CW{1'b0}}) || (drop_cnt != {CW{1'b0}})));

   a_req_aligned: assert property (@(posedge clk_100mhz) disable iff (!rst_in)
      req_valid |-> (req_addr[1:0] == 2'b00));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues in-order word reads and buffers responses for decode.
// Responses to requests issued before a redirect are discarded by counting them in drop_cnt_r.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk_100mhz,
   input  logic        rst_in,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_in,
   input  logic [31:0] redirect_pc_in,
   output logic        inst_valid_out,
   input  logic        inst_ready_in,
   output logic [31:0] inst_out,
   output logic [31:0] pc_out
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   logic [31:0]   fetch_pc_r;
   logic [CW-1:0] drop_cnt_r;
   logic          req_valid_r;

   logic          req_fire_s;
   logic          alloc_s;
   logic          fill_s;
   logic          pop_s;
   logic          head_valid_s;
   fetch_entry_t  head_s;
   logic [CW-1:0] count_s;
   logic [CW-1:0] unfilled_s;
   logic [CW-1:0] count_next_s;
   logic [CW-1:0] drop_next_s;
   logic [CW:0]   credit_next_s;

   // Handshakes and next-state occupancy; redirect squashes allocation and fill.
   always_comb begin
      req_fire_s   = req_valid_r & imem_req_ready;
      head_valid_s = (count_s != {CW{1'b0}}) & head_s.filled;
      pop_s        = head_valid_s & inst_ready_in;
      alloc_s      = req_fire_s & ~redirect_in;
      fill_s       = imem_resp_valid & (drop_cnt_r == {CW{1'b0}}) & ~redirect_in;
      if (redirect_in) begin
         count_next_s = {CW{1'b0}};
         drop_next_s  = drop_cnt_r + unfilled_s + CW'(req_fire_s) - CW'(imem_resp_valid);
      end else begin
         count_next_s = count_s + CW'(alloc_s) - CW'(pop_s);
         if (imem_resp_valid && (drop_cnt_r != {CW{1'b0}})) begin
            drop_next_s = drop_cnt_r - CW'(1);
         end else begin
            drop_next_s = drop_cnt_r;
         end
      end
      credit_next_s = {1'b0, count_next_s} + {1'b0, drop_next_s};
   end

   // PC, discard counter and the registered request-valid credit check.
   always_ff @(posedge clk_100mhz or negedge rst_in) begin
      if (!rst_in) begin
         fetch_pc_r  <= RESET_PC;
         drop_cnt_r  <= {CW{1'b0}};
         req_valid_r <= 1'b0;
      end else begin
         drop_cnt_r  <= drop_next_s;
         req_valid_r <= credit_next_s < (CW+1)'(FIFO_DEPTH);
         if (redirect_in) begin
            fetch_pc_r <= word_align(redirect_pc_in);
         end else if (req_fire_s) begin
            fetch_pc_r <= fetch_pc_r + 32'd4;
         end else begin
            fetch_pc_r <= fetch_pc_r;
         end
      end
   end

   fetch_buffer #(.DEPTH(FIFO_DEPTH)) u_buffer (
      .clk_100mhz (clk_100mhz),
      .rst_in     (rst_in),
      .alloc      (alloc_s),
      .alloc_pc   (fetch_pc_r),
      .fill       (fill_s),
      .fill_inst  (imem_resp_data),
      .pop        (pop_s),
      .flush      (redirect_in),
      .head       (head_s),
      .count      (count_s),
      .unfilled   (unfilled_s)
   );

   fetch_unit_checker #(.CW(CW)) u_checker (
      .clk_100mhz (clk_100mhz),
      .rst_in     (rst_in),
      .resp_valid (imem_resp_valid),
      .req_valid  (imem_req_valid),
      .req_addr   (imem_req_addr),
      .unfilled   (unfilled_s),
      .drop_cnt   (drop_cnt_r)
   );

   // Output presentation; idle values when the head is not ready.
   always_comb begin
      imem_req_valid = req_valid_r;
      imem_req_addr  = fetch_pc_r;
      inst_valid_out = head_valid_s;
      if (head_valid_s) begin
         inst_out = head_s.inst;
         pc_out   = head_s.pc;
      end else begin
         inst_out = INST_NOP;
         pc_out   = 32'h0000_0000;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit.
// The reference model tracks in-flight requests (live or squashed) and delivered-ready PCs as queues.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam int DEPTH = 4;

   logic        clk_100mhz = 1'b0;
   logic        rst_in = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = 32'h0000_0000;
   logic        redirect_in = 1'b0;
   logic [31:0] redirect_pc_in = 32'h0000_0000;
   logic        inst_valid_out;
   logic        inst_ready_in = 1'b0;
   logic [31:0] inst_out;
   logic [31:0] pc_out;

   always #5 clk_100mhz = ~clk_100mhz;

   fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
      .clk_100mhz      (clk_100mhz),
      .rst_in          (rst_in),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .redirect_in     (redirect_in),
      .redirect_pc_in  (redirect_pc_in),
      .inst_valid_out  (inst_valid_out),
      .inst_ready_in   (inst_ready_in),
      .inst_out        (inst_out),
      .pc_out          (pc_out)
   );

   typedef struct {
      logic [31:0] pc;
      bit          live;
      int          due;
   } req_t;

   req_t        inflight[$];
   logic [31:0] held[$];
   logic [31:0] next_req_pc;
   int          cycle = 0;
   int          edges = 0;
   int          lat = 1;
   int          pops = 0;
   int          n_checks = 0;
   int          n_pass = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0000;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
   endtask

   // One clock cycle: compare outputs with the model, drive inputs, advance the model at the edge.
   task automatic cyc(input logic rdy, input logic ird, input logic rd, input logic [31:0] rpc);
      logic req_f, pop_f, resp_f;
      logic [31:0] req_pc;
      req_t r;
      if (edges > 0)
         check_eq("req_valid", 32'(imem_req_valid), 32'((inflight.size() + held.size()) < DEPTH));
      if (imem_req_valid) check_eq("req_addr", imem_req_addr, next_req_pc);
      check_eq("inst_valid", 32'(inst_valid_out), 32'(held.size() > 0));
      if (inst_valid_out && held.size() > 0) begin
         check_eq("pc_out", pc_out, held[0]);
         check_eq("inst_out", inst_out, mem_word(held[0]));
      end else if (!inst_valid_out) begin
         check_eq("idle_inst", inst_out, INST_NOP);
         check_eq("idle_pc", pc_out, 32'h0000_0000);
      end
      resp_f = (inflight.size() > 0) && (inflight[0].due <= cycle);
      imem_resp_valid = resp_f;
      imem_resp_data  = resp_f ? mem_word(inflight[0].pc) : 32'h0000_0000;
      imem_req_ready  = rdy;
      inst_ready_in   = ird;
      redirect_in     = rd;
      redirect_pc_in  = rpc;
      req_f  = imem_req_valid && rdy;
      pop_f  = inst_valid_out && ird;
      req_pc = imem_req_addr;
      @(posedge clk_100mhz);
      cycle++;
      edges++;
      if (pop_f) begin
         pops++;
         if (held.size() > 0) void'(held.pop_front());
      end
      if (resp_f) begin
         r = inflight.pop_front();
         if (r.live && !rd) held.push_back(r.pc);
      end
      if (req_f) begin
         inflight.push_back('{pc: req_pc, live: !rd, due: cycle + lat - 1});
         next_req_pc = next_req_pc + 32'd4;
      end
      if (rd) begin
         held.delete();
         foreach (inflight[i]) inflight[i].live = 1'b0;
         next_req_pc = rpc & 32'hFFFF_FFFC;
      end
      @(negedge clk_100mhz);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
      check_eq({tag, "_req_addr"}, imem_req_addr, 32'h0000_0000);
      check_eq({tag, "_inst_valid"}, 32'(inst_valid_out), 32'd0);
      check_eq({tag, "_inst"}, inst_out, INST_NOP);
      check_eq({tag, "_pc"}, pc_out, 32'h0000_0000);
   endtask

   task automatic model_reset();
      inflight.delete();
      held.delete();
      next_req_pc     = 32'h0000_0000;
      edges           = 0;
      imem_resp_valid = 1'b0;
      imem_req_ready  = 1'b0;
      inst_ready_in   = 1'b0;
      redirect_in     = 1'b0;
   endtask

   initial begin
      int p0;
      int guard;
      model_reset();
      #12;
      check_reset_outputs("reset");
      @(negedge clk_100mhz);
      rst_in = 1'b1;

      // Steady state: latency 1, always ready -> one instruction per cycle.
      lat = 1;
      for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0);
      p0 = pops;
      for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0);
      check_eq("throughput", 32'(pops - p0), 32'd20);

      // Redirect in the same cycle as a pop and a response.
      check_eq("pre_redirect_valid", 32'(inst_valid_out & imem_resp_valid), 32'd1);
      cyc(1'b1, 1'b1, 1'b1, 32'h0000_0300);
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0);

      // Decode stalled: buffer fills and requests stop.
      for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0);
      check_eq("stall_req_valid", 32'(imem_req_valid), 32'd0);
      check_eq("stall_head_valid", 32'(inst_valid_out), 32'd1);
      for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0);

      // Latency 3 with two requests outstanding, then redirect to 0x100.
      lat = 3;
      cyc(1'b1, 1'b1, 1'b1, 32'h0000_0500);
      guard = 0;
      while (inflight.size() != 2 && guard < 20) begin
         cyc(1'b1, 1'b1, 1'b0, 32'h0);
         guard++;
      end
      check_eq("two_outstanding_reached", 32'(guard < 20), 32'd1);
      cyc(1'b1, 1'b1, 1'b1, 32'h0000_0100);
      check_eq("redirect_addr", imem_req_addr, 32'h0000_0100);
      guard = 0;
      while (!inst_valid_out && guard < 30) begin
         cyc(1'b1, 1'b1, 1'b0, 32'h0);
         guard++;
      end
      check_eq("first_pc_after_redirect", pc_out, 32'h0000_0100);

      // Unaligned redirect and back-to-back redirects.
      lat = 1;
      cyc(1'b1, 1'b1, 1'b1, 32'h0000_0203);
      check_eq("aligned_addr", imem_req_addr, 32'h0000_0200);
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0);
      cyc(1'b1, 1'b1, 1'b1, 32'h0000_0040);
      cyc(1'b1, 1'b1, 1'b1, 32'h0000_0080);
      guard = 0;
      while (!inst_valid_out && guard < 30) begin
         cyc(1'b1, 1'b1, 1'b0, 32'h0);
         guard++;
      end
      check_eq("b2b_first_pc", pc_out, 32'h0000_0080);

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         if (i % 100 == 0) lat = int'($urandom_range(1, 4));
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 19) == 0, $urandom);
      end

      // Asynchronous reset between clock edges.
      lat = 2;
      for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0);
      @(posedge clk_100mhz);
      #3;
      rst_in = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      model_reset();
      @(negedge clk_100mhz);
      @(negedge clk_100mhz);
      check_reset_outputs("held_reset");
      rst_in = 1'b1;
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0);
      guard = 0;
      while (!inst_valid_out && guard < 20) begin
         cyc(1'b1, 1'b1, 1'b0, 32'h0);
         guard++;
      end
      check_eq("restart_pc", pc_out, 32'h0000_0000);
      for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
